stabilizer_row_streamer: RTL

Transmit-side companion to the canonical-form block. Holds a num_qubit-row stabilizer tableau in local registers, accepts row writes while idle, and on request emits a one-cycle `start` pulse followed by all num_qubit rows on consecutive cycles with `valid_out` high. This matches the canonical-form input protocol: reset on `start`, then rows must arrive on contiguous valid cycles. The block sits between the gate-update datapath or testbench loader and the canonical-form input.

---
 rtl/stabilizer_row_streamer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/stabilizer_row_streamer.sv
// Holds a num_qubit-row stabilizer tableau and streams it as a start pulse
// followed by num_qubit contiguous valid rows, for the canonical-form input.
module stabilizer_row_streamer #(
  parameter int num_qubit = 4,
  localparam int AW = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [0:num_qubit-1][1:0]    wr_literals,
  input  logic                         wr_phase,
  input  logic                         clear,
  input  logic                         send,
  output logic                         ready,
  output logic                         start,
  output logic [0:num_qubit-1][1:0]    literals_out,
  output logic                         phase_out,
  output logic                         valid_out,
  output logic                         done,
  output logic                         wr_drop
);

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(num_qubit - 1);

  state_t                       state_q;
  logic [AW-1:0]                row_q;
  logic [0:num_qubit-1][1:0]    lit_mem_q [num_qubit];
  logic                         ph_mem_q  [num_qubit];

  logic                         ready_q, start_q, valid_q, done_q, drop_q, ph_q;
  logic [0:num_qubit-1][1:0]    lit_q;

  logic [AW:0]                  addr_ext;
  logic                         addr_ok;
  logic                         clear_accept;
  logic                         wr_accept;
  logic                         drop_d;
  logic [AW-1:0]                row_d;

  // Row r of the |0...0> stabilizer tableau: Z on qubit r, identity elsewhere.
  function automatic logic [0:num_qubit-1][1:0] identity_row(input int r);
    logic [0:num_qubit-1][1:0] row;
    row = '0;
    for (int j = 0; j < num_qubit; j++) begin
      if (j == r) row[j] = 2'b10;
    end
    return row;
  endfunction

  assign addr_ext     = {1'b0, wr_addr};
  assign addr_ok      = addr_ext < (AW+1)'(num_qubit);
  assign clear_accept = (state_q == IDLE) && clear;
  assign wr_accept    = (state_q == IDLE) && wr_en && addr_ok && !clear;
  assign drop_d       = wr_en && !wr_accept;
  assign row_d        = row_q + AW'(1);

  // Storage only changes in IDLE, so every stream is a consistent snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < num_qubit; r++) begin
        lit_mem_q[r] <= identity_row(r);
        ph_mem_q[r]  <= 1'b0;
      end
    end else if (clear_accept) begin
      for (int r = 0; r < num_qubit; r++) begin
        lit_mem_q[r] <= identity_row(r);
        ph_mem_q[r]  <= 1'b0;
      end
    end else if (wr_accept) begin
      lit_mem_q[wr_addr] <= wr_literals;
      ph_mem_q[wr_addr]  <= wr_phase;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      lit_q   <= '0;
      ph_q    <= 1'b0;
    end else begin
      drop_q  <= drop_d;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      lit_q   <= '0;
      ph_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send) begin
            state_q <= START;
            start_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        START: begin
          state_q <= STREAM;
          row_q   <= '0;
          valid_q <= 1'b1;
          lit_q   <= lit_mem_q[0];
          ph_q    <= ph_mem_q[0];
        end
        STREAM: begin
          // Output registers already hold row_q; preload the next row or finish.
          if (row_q == LAST_ROW) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            row_q   <= row_d;
            valid_q <= 1'b1;
            lit_q   <= lit_mem_q[row_d];
            ph_q    <= ph_mem_q[row_d];
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign start        = start_q;
  assign valid_out    = valid_q;
  assign done         = done_q;
  assign wr_drop      = drop_q;
  assign literals_out = lit_q;
  assign phase_out    = ph_q;

endmodule
